// File: rtl/audio_frame_capture_pkg.sv
// Shared audio definitions: sample type, capture FSM state encoding and a
// magnitude helper used by the trigger qualifier.
package audio_frame_capture_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Capture FSM state encoding (kept as plain constants for legacy tooling).
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_TRIG = 2'd1;
  localparam logic [1:0] ST_CAPTURE   = 2'd2;
  localparam logic [1:0] ST_FULL      = 2'd3;

  // Unsigned magnitude of a signed sample, one bit wider so that the most
  // negative value (-32768) maps to 32768 instead of wrapping.
  function automatic logic [SAMPLE_W:0] sample_mag(input sample_t s);
    logic [SAMPLE_W:0] ext;
    ext = {s[SAMPLE_W-1], s};
    if (ext[SAMPLE_W]) begin
      sample_mag = ~ext + {{SAMPLE_W{1'b0}}, 1'b1};
    end else begin
      sample_mag = ext;
    end
  endfunction

endpackage

// File: rtl/audio_frame_ram.sv
// Simple dual-port synchronous sample buffer: one write port and one
// registered read port. Reading and writing the same address in one cycle
// returns the previous contents. Contents are not reset so the array maps
// onto block RAM.
module audio_frame_ram
  import audio_frame_capture_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  sample_t           i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output sample_t           o_rdata
);

  sample_t r_mem [0:(1<<ADDR_W)-1];
  sample_t r_rdata;

  // Write port: store the incoming sample when enabled.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: registered read, sees the value before any same-cycle write.
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/audio_frame_capture.sv
// Audio frame capture: fills a FRAME_LEN-sample buffer from a valid-qualified
// sample stream after each arm, pulses frame_done when the frame is complete
// and serves the frame through a 1-cycle-latency random-access read port.
// Optional build macro CAPT_TRIG_EN: after arm, samples are discarded until
// one reaches a magnitude of TRIG_LEVEL; that sample becomes frame index 0.
module audio_frame_capture
  import audio_frame_capture_pkg::*;
#(
  parameter int          FRAME_LEN  = 1024,
  parameter int          ADDR_W     = 10,
  parameter logic [15:0] TRIG_LEVEL = 16'd512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              in_valid,
  input  sample_t           in_sample,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output sample_t           rd_data,
  output logic [ADDR_W:0]   wr_count,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam logic [ADDR_W:0] LP_FRAME_LEN = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0] LP_LAST_IDX  = (ADDR_W+1)'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] LP_ONE       = {{ADDR_W{1'b0}}, 1'b1};

`ifdef CAPT_TRIG_EN
  localparam logic [1:0] LP_ARM_STATE = ST_WAIT_TRIG;
`else
  localparam logic [1:0] LP_ARM_STATE = ST_CAPTURE;
  // The threshold only matters in the triggered build.
  logic w_unused_trig;
  assign w_unused_trig = ^TRIG_LEVEL;
`endif

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_wr_count;
  logic              r_frame_done;
  logic              r_overflow;
  logic              r_active;
  logic              r_rd_valid;

  logic [1:0]        w_state_nxt;
  logic [ADDR_W:0]   w_wr_count_nxt;
  logic              w_frame_done_nxt;
  logic              w_overflow_nxt;
  logic              w_active_nxt;
  logic              w_accept;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  sample_t           w_ram_q;

  // in_ready and busy are both high exactly in WAIT_TRIG and CAPTURE.
  assign w_accept = in_valid & r_active;

  // Next-state, write-enable and status decode for the capture FSM.
  always_comb begin
    w_state_nxt      = r_state;
    w_wr_count_nxt   = r_wr_count;
    w_frame_done_nxt = 1'b0;
    w_overflow_nxt   = r_overflow;
    w_we             = 1'b0;
    w_waddr          = r_wr_count[ADDR_W-1:0];
    case (r_state)
      ST_IDLE: begin
        if (arm) begin
          w_state_nxt    = LP_ARM_STATE;
          w_wr_count_nxt = '0;
          w_overflow_nxt = 1'b0;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_WAIT_TRIG: begin
`ifdef CAPT_TRIG_EN
        if (w_accept && (sample_mag(in_sample) >= {1'b0, TRIG_LEVEL})) begin
          w_we           = 1'b1;
          w_waddr        = '0;
          w_wr_count_nxt = LP_ONE;
          w_state_nxt    = ST_CAPTURE;
        end else begin
          w_state_nxt    = ST_WAIT_TRIG;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_CAPTURE: begin
        if (w_accept) begin
          w_we           = 1'b1;
          w_wr_count_nxt = r_wr_count + LP_ONE;
          if (r_wr_count == LP_LAST_IDX) begin
            w_state_nxt      = ST_FULL;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_state_nxt      = ST_CAPTURE;
          end
        end else begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_FULL: begin
        if (arm) begin
          w_state_nxt    = LP_ARM_STATE;
          w_wr_count_nxt = '0;
          w_overflow_nxt = 1'b0;
        end else if (in_valid) begin
          w_overflow_nxt = 1'b1;
        end else begin
          w_state_nxt    = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_active_nxt = (w_state_nxt == ST_CAPTURE) || (w_state_nxt == ST_WAIT_TRIG);
  end

  // FSM and status registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wr_count   <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_count   <= w_wr_count_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_overflow   <= w_overflow_nxt;
      r_active     <= w_active_nxt;
    end
  end

  // Remember whether the address presented last cycle lies inside the frame;
  // out-of-frame reads and the reset state both return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= ({1'b0, rd_addr} < LP_FRAME_LEN);
    end
  end

  audio_frame_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (in_sample),
    .i_raddr (rd_addr),
    .o_rdata (w_ram_q)
  );

  assign rd_data    = r_rd_valid ? w_ram_q : '0;
  assign in_ready   = r_active;
  assign busy       = r_active;
  assign wr_count   = r_wr_count;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_audio_frame_capture.sv
// Directed, table-driven bench for audio_frame_capture with FRAME_LEN=8.
module tb_audio_frame_capture;

  typedef struct {
    logic        arm;
    logic        vld;
    logic [15:0] smp;
    logic [3:0]  ra;
    logic        crd;
    logic [15:0] rd;
    logic        rdy;
    logic        bsy;
    logic [4:0]  wc;
    logic        fd;
    logic        ov;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        in_valid;
  logic [15:0] in_sample;
  logic        in_ready;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [4:0]  wr_count;
  logic        busy;
  logic        frame_done;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  audio_frame_capture #(
    .FRAME_LEN  (8),
    .ADDR_W     (4),
    .TRIG_LEVEL (16'd512)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .in_ready   (in_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_count   (wr_count),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic a, input logic v, input logic [15:0] s,
                              input logic [3:0] ra, input logic crd, input logic [15:0] rd,
                              input logic rdy, input logic bsy, input logic [4:0] wc,
                              input logic fd, input logic ov);
    vec_t t;
    t.arm = a;   t.vld = v;   t.smp = s;  t.ra = ra; t.crd = crd; t.rd = rd;
    t.rdy = rdy; t.bsy = bsy; t.wc = wc;  t.fd = fd; t.ov = ov;
    return t;
  endfunction

  // Drive one cycle of inputs, then compare outputs 1 time unit after the edge.
  task automatic apply(input vec_t t, input string tag);
    arm       = t.arm;
    in_valid  = t.vld;
    in_sample = t.smp;
    rd_addr   = t.ra;
    @(posedge clk);
    #1;
    chk({tag, ".in_ready"},   {31'd0, in_ready},   {31'd0, t.rdy});
    chk({tag, ".busy"},       {31'd0, busy},       {31'd0, t.bsy});
    chk({tag, ".wr_count"},   {27'd0, wr_count},   {27'd0, t.wc});
    chk({tag, ".frame_done"}, {31'd0, frame_done}, {31'd0, t.fd});
    chk({tag, ".overflow"},   {31'd0, overflow},   {31'd0, t.ov});
    if (t.crd) begin
      chk({tag, ".rd_data"}, {16'd0, rd_data}, {16'd0, t.rd});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".in_ready"},   {31'd0, in_ready},   32'd0);
    chk({tag, ".busy"},       {31'd0, busy},       32'd0);
    chk({tag, ".wr_count"},   {27'd0, wr_count},   32'd0);
    chk({tag, ".frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, ".overflow"},   {31'd0, overflow},   32'd0);
    chk({tag, ".rd_data"},    {16'd0, rd_data},    32'd0);
  endtask

  initial begin
    vec_t tbl[$];
    rst       = 1'b1;
    arm       = 1'b0;
    in_valid  = 1'b0;
    in_sample = 16'd0;
    rd_addr   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

`ifdef CAPT_TRIG_EN
    // Trigger: 10 and -511 are below 512 and dropped; -512 starts the frame.
    apply(mk(1'b1, 1'b0, 16'd0,    4'd0, 1'b0, 16'd0,    1'b1, 1'b1, 5'd0, 1'b0, 1'b0), "trg0");
    apply(mk(1'b0, 1'b1, 16'd10,   4'd0, 1'b0, 16'd0,    1'b1, 1'b1, 5'd0, 1'b0, 1'b0), "trg1");
    apply(mk(1'b0, 1'b1, 16'hFE01, 4'd0, 1'b0, 16'd0,    1'b1, 1'b1, 5'd0, 1'b0, 1'b0), "trg2");
    apply(mk(1'b0, 1'b1, 16'hFE00, 4'd0, 1'b0, 16'd0,    1'b1, 1'b1, 5'd1, 1'b0, 1'b0), "trg3");
    apply(mk(1'b0, 1'b1, 16'd3,    4'd0, 1'b0, 16'd0,    1'b1, 1'b1, 5'd2, 1'b0, 1'b0), "trg4");
    apply(mk(1'b0, 1'b0, 16'd0,    4'd0, 1'b1, 16'hFE00, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0), "trg5");
    apply(mk(1'b0, 1'b0, 16'd0,    4'd1, 1'b1, 16'd3,    1'b1, 1'b1, 5'd2, 1'b0, 1'b0), "trg6");
    rst = 1'b1;
    #2;
    rst = 1'b0;
    // Most negative sample has magnitude 32768 and must trigger.
    apply(mk(1'b1, 1'b0, 16'd0,    4'd0, 1'b0, 16'd0,    1'b1, 1'b1, 5'd0, 1'b0, 1'b0), "neg0");
    apply(mk(1'b0, 1'b1, 16'h8000, 4'd0, 1'b0, 16'd0,    1'b1, 1'b1, 5'd1, 1'b0, 1'b0), "neg1");
    apply(mk(1'b0, 1'b1, 16'd1,    4'd0, 1'b0, 16'd0,    1'b1, 1'b1, 5'd2, 1'b0, 1'b0), "neg2");
    apply(mk(1'b0, 1'b0, 16'd0,    4'd0, 1'b1, 16'h8000, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0), "neg3");
`else
    // Full frame 1..8, overflow in FULL, read-back, out-of-frame read, re-arm.
    tbl.push_back(mk(1'b1, 1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0));
    for (int k = 1; k <= 8; k++) begin
      tbl.push_back(mk(1'b0, 1'b1, 16'(k), 4'd0, 1'b0, 16'd0,
                       (k < 8), (k < 8), 5'(k), (k == 8), 1'b0));
    end
    tbl.push_back(mk(1'b0, 1'b0, 16'd0,    4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 16'h1234, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 16'd0,    4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1));
    for (int a = 0; a < 8; a++) begin
      tbl.push_back(mk(1'b0, 1'b0, 16'd0, 4'(a), 1'b1, 16'(a + 1), 1'b0, 1'b0, 5'd8, 1'b0, 1'b1));
    end
    tbl.push_back(mk(1'b0, 1'b0, 16'd0, 4'd9, 1'b1, 16'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0));
    // Gapped input 100, -100, 7 with junk data on invalid cycles.
    tbl.push_back(mk(1'b0, 1'b1, 16'd100,  4'd0, 1'b0, 16'd0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 16'h5555, 4'd0, 1'b0, 16'd0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 16'hFF9C, 4'd0, 1'b0, 16'd0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 16'h6666, 4'd0, 1'b0, 16'd0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 16'd7,    4'd0, 1'b0, 16'd0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 16'd0, 4'd0, 1'b1, 16'd100,  1'b1, 1'b1, 5'd3, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 16'd0, 4'd1, 1'b1, 16'hFF9C, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 16'd0, 4'd2, 1'b1, 16'd7,    1'b1, 1'b1, 5'd3, 1'b0, 1'b0));
    // arm while busy is ignored; address 3 still holds the old frame's 4.
    tbl.push_back(mk(1'b1, 1'b0, 16'd0, 4'd3, 1'b1, 16'd4,    1'b1, 1'b1, 5'd3, 1'b0, 1'b0));
    // Same-address read and write returns old data, new data next cycle.
    tbl.push_back(mk(1'b0, 1'b1, 16'd55, 4'd3, 1'b1, 16'd4,   1'b1, 1'b1, 5'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 16'd0,  4'd3, 1'b1, 16'd55,  1'b1, 1'b1, 5'd4, 1'b0, 1'b0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("t%0d", i));
    end

    // Reset mid-frame (4 of 8 written): outputs clear without waiting for a clock.
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      apply(mk(1'b0, 1'b1, 16'h0AAA, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0),
            $sformatf("post_rst%0d", i));
    end

    // arm held while the final sample is accepted: frame completes, no restart.
    apply(mk(1'b1, 1'b0, 16'd0, 4'd0, 1'b0, 16'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0), "bnd_arm");
    for (int k = 1; k <= 7; k++) begin
      apply(mk(1'b0, 1'b1, 16'(10 + k), 4'd0, 1'b0, 16'd0, 1'b1, 1'b1, 5'(k), 1'b0, 1'b0),
            $sformatf("bnd%0d", k));
    end
    apply(mk(1'b1, 1'b1, 16'd18, 4'd0, 1'b0, 16'd0,  1'b0, 1'b0, 5'd8, 1'b1, 1'b0), "bnd8");
    apply(mk(1'b0, 1'b0, 16'd0,  4'd9, 1'b1, 16'd0,  1'b0, 1'b0, 5'd8, 1'b0, 1'b0), "bnd_oob");
    apply(mk(1'b0, 1'b0, 16'd0,  4'd7, 1'b1, 16'd18, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0), "bnd_rd7");
    apply(mk(1'b0, 1'b0, 16'd0,  4'd0, 1'b1, 16'd11, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0), "bnd_rd0");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
